ew_skid_reg: RTL and testbench
==============================

// Module: ew_skid_reg
// PURPOSE
//  Parametrised execute->writeback pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Carries pc, op, source/target operands, immediate/displacement, write register and ALU result.
//  Lets writeback stall without a combinational ready path back into execute.
//  Supports flush and bubble sanitising (NOP op never writes a register). Counts stall cycles.
// PARAMETERS
//  PC_W    32     pc width
//  OP_W    6      opcode width
//  DATA_W  32     width of os, ot, imm_dpl, result
//  REG_W   5      register index width
//  NOP_OP  55     opcode treated as bubble/NOP
//  CNT_W   16     stall counter width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rstd         in   1       reset, synchronous, active-high (1 = reset)
//  flush        in   1       synchronous squash of all held entries
//  in_valid     in   1       execute presents a valid entry
//  in_ready     out  1       register can accept (registered, = !skid_valid)
//  pc_in        in   PC_W    pc
//  op_in        in   OP_W    opcode
//  os_in        in   DATA_W  source operand
//  ot_in        in   DATA_W  target operand
//  imm_dpl_in   in   DATA_W  immediate/displacement
//  wreg_in      in   REG_W   destination register
//  result_in    in   DATA_W  execute result
//  out_valid    out  1       main entry valid
//  out_ready    in   1       writeback consumes main entry this cycle
//  pc_out, op_out, os_out, ot_out, imm_dpl_out, wreg_out, result_out  out  (as inputs)  main entry
//  stall_cnt    out  CNT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - Sanitise on capture: if op_in==NOP_OP, stored wreg = 0; all other fields stored as given.
//  - States (main_v, skid_v): EMPTY(0,0), ONE(1,0), TWO(1,1). skid valid never without main.
//  - EMPTY: push -> ONE, main <= in.
//  - ONE: push&pop -> ONE, main <= in; push only -> TWO, skid <= in; pop only -> EMPTY.
//  - TWO: in_ready=0; pop -> ONE, main <= skid; else hold.
//  - Order preserved: skid entry always older than any later push; never overwritten while valid.
//  - Latency 1 cycle (EMPTY, push at edge N -> out_valid from N+1); sustained throughput 1/cycle.
//  - When out_valid=0: op_out = NOP_OP, wreg_out = 0; other outputs hold last value (don't care).
//  - flush=1: next state EMPTY, in_valid input of that cycle dropped, in_ready=1 next cycle.
//    Flush wins over push/pop. stall_cnt not cleared by flush.
//  - stall_cnt: +1 per cycle with out_valid & !out_ready; saturates at 2^CNT_W-1.
//  - Reset (rstd=1 at edge) overrides everything: EMPTY, in_ready=1, out_valid=0,
//    op_out=NOP_OP, wreg_out=0, all payload regs 0, stall_cnt=0. Mid-transfer entries discarded.
//  - No combinational path from out_ready to in_ready.
// STRUCTURE
//  - Package pipe_pkg: NOP_OP constant (6'd55), default widths, packed ew_payload_t struct.
//  - Sub-module pipe_slot: one payload register + valid bit with load/clear and NOP sanitise;
//    instantiated twice (main, skid). Top holds state logic, output muxing, stall counter.
// TESTING
//  1. Reset: rstd=1 one cycle -> out_valid=0, in_ready=1, op_out=55, wreg_out=0, stall_cnt=0.
//  2. Streaming: 8 entries, out_ready=1 -> each appears 1 cycle later in order, in_ready stays 1.
//  3. Back-pressure: push A,B with out_ready=0 -> in_ready=0 after B, out=A; stall_cnt=2 after 2 cycles;
//     release -> A then B, no loss/duplication.
//  4. Bubble: push op=55, wreg=7 -> out_valid=1, op_out=55, wreg_out=0; op=0, wreg=7 -> wreg_out=7.
//  5. Flush in TWO with in_valid=1 -> next cycle out_valid=0, op_out=55, in_ready=1; dropped entry never appears.
//  6. Saturation: CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt=15 and stays.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and payload layout for the execute->writeback pipeline register.
package pipe_pkg;
    localparam int PC_W_D   = 32;
    localparam int OP_W_D   = 6;
    localparam int DATA_W_D = 32;
    localparam int REG_W_D  = 5;
    localparam int CNT_W_D  = 16;
    localparam logic [5:0] NOP_OP = 6'd55;

    typedef struct packed {
        logic [PC_W_D-1:0]   pc;
        logic [OP_W_D-1:0]   op;
        logic [DATA_W_D-1:0] os;
        logic [DATA_W_D-1:0] ot;
        logic [DATA_W_D-1:0] imm_dpl;
        logic [REG_W_D-1:0]  wreg;
        logic [DATA_W_D-1:0] result;
    } ew_payload_t;
endpackage

// File: rtl/pipe_slot.sv
// One payload register plus valid bit; a NOP opcode never carries a write register.
import pipe_pkg::*;

module pipe_slot #(
    parameter int PC_W   = PC_W_D,
    parameter int OP_W   = OP_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int REG_W  = REG_W_D,
    parameter int NOP_V  = 55
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              i_ld,
    input  logic              i_clr,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_os,
    input  logic [DATA_W-1:0] i_ot,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [REG_W-1:0]  i_wreg,
    input  logic [DATA_W-1:0] i_res,
    output logic              o_valid,
    output logic [PC_W-1:0]   o_pc,
    output logic [OP_W-1:0]   o_op,
    output logic [DATA_W-1:0] o_os,
    output logic [DATA_W-1:0] o_ot,
    output logic [DATA_W-1:0] o_imm,
    output logic [REG_W-1:0]  o_wreg,
    output logic [DATA_W-1:0] o_res
);
    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_os, r_ot, r_imm, r_res;
    logic [REG_W-1:0]  r_wreg;
    logic              w_nop;

    assign w_nop = (i_op == OP_W'(NOP_V));

    always_ff @(posedge clk) begin
        if (rstd) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_op    <= '0;
            r_os    <= '0;
            r_ot    <= '0;
            r_imm   <= '0;
            r_wreg  <= '0;
            r_res   <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_ld) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_op    <= i_op;
            r_os    <= i_os;
            r_ot    <= i_ot;
            r_imm   <= i_imm;
            r_wreg  <= w_nop ? '0 : i_wreg;
            r_res   <= i_res;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_op    = r_op;
    assign o_os    = r_os;
    assign o_ot    = r_ot;
    assign o_imm   = r_imm;
    assign o_wreg  = r_wreg;
    assign o_res   = r_res;
endmodule

// File: rtl/ew_skid_reg.sv
// Execute->writeback register with a 2-entry skid buffer; in_ready depends only on state,
// so writeback back-pressure never forms a combinational path into execute.
import pipe_pkg::*;

module ew_skid_reg #(
    parameter int PC_W   = PC_W_D,
    parameter int OP_W   = OP_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int REG_W  = REG_W_D,
    parameter int NOP_OP = 55,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [OP_W-1:0]   op_in,
    input  logic [DATA_W-1:0] os_in,
    input  logic [DATA_W-1:0] ot_in,
    input  logic [DATA_W-1:0] imm_dpl_in,
    input  logic [REG_W-1:0]  wreg_in,
    input  logic [DATA_W-1:0] result_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [OP_W-1:0]   op_out,
    output logic [DATA_W-1:0] os_out,
    output logic [DATA_W-1:0] ot_out,
    output logic [DATA_W-1:0] imm_dpl_out,
    output logic [REG_W-1:0]  wreg_out,
    output logic [DATA_W-1:0] result_out,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              w_main_v, w_skid_v, w_push, w_pop;
    logic              w_main_ld, w_main_clr, w_skid_ld, w_skid_clr;
    logic [PC_W-1:0]   w_m_pc, w_s_pc, w_d_pc;
    logic [OP_W-1:0]   w_m_op, w_s_op, w_d_op;
    logic [DATA_W-1:0] w_m_os, w_s_os, w_d_os, w_m_ot, w_s_ot, w_d_ot;
    logic [DATA_W-1:0] w_m_imm, w_s_imm, w_d_imm, w_m_res, w_s_res, w_d_res;
    logic [REG_W-1:0]  w_m_wreg, w_s_wreg, w_d_wreg;
    logic [CNT_W-1:0]  r_stall;

    assign in_ready = !w_skid_v;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_main_v && out_ready;

    // Main refills from skid when skid holds the older entry, otherwise straight from execute.
    assign w_main_ld  = !flush && ((w_pop && w_skid_v) || (w_push && (!w_main_v || w_pop)));
    assign w_main_clr = flush || (w_pop && !w_skid_v && !w_push);
    assign w_skid_ld  = !flush && w_push && w_main_v && !w_pop;
    assign w_skid_clr = flush || (w_pop && w_skid_v);

    assign w_d_pc   = w_skid_v ? w_s_pc   : pc_in;
    assign w_d_op   = w_skid_v ? w_s_op   : op_in;
    assign w_d_os   = w_skid_v ? w_s_os   : os_in;
    assign w_d_ot   = w_skid_v ? w_s_ot   : ot_in;
    assign w_d_imm  = w_skid_v ? w_s_imm  : imm_dpl_in;
    assign w_d_wreg = w_skid_v ? w_s_wreg : wreg_in;
    assign w_d_res  = w_skid_v ? w_s_res  : result_in;

    pipe_slot #(.PC_W(PC_W), .OP_W(OP_W), .DATA_W(DATA_W), .REG_W(REG_W), .NOP_V(NOP_OP)) u_main (
        .clk(clk), .rstd(rstd), .i_ld(w_main_ld), .i_clr(w_main_clr),
        .i_pc(w_d_pc), .i_op(w_d_op), .i_os(w_d_os), .i_ot(w_d_ot), .i_imm(w_d_imm),
        .i_wreg(w_d_wreg), .i_res(w_d_res),
        .o_valid(w_main_v), .o_pc(w_m_pc), .o_op(w_m_op), .o_os(w_m_os), .o_ot(w_m_ot),
        .o_imm(w_m_imm), .o_wreg(w_m_wreg), .o_res(w_m_res)
    );

    pipe_slot #(.PC_W(PC_W), .OP_W(OP_W), .DATA_W(DATA_W), .REG_W(REG_W), .NOP_V(NOP_OP)) u_skid (
        .clk(clk), .rstd(rstd), .i_ld(w_skid_ld), .i_clr(w_skid_clr),
        .i_pc(pc_in), .i_op(op_in), .i_os(os_in), .i_ot(ot_in), .i_imm(imm_dpl_in),
        .i_wreg(wreg_in), .i_res(result_in),
        .o_valid(w_skid_v), .o_pc(w_s_pc), .o_op(w_s_op), .o_os(w_s_os), .o_ot(w_s_ot),
        .o_imm(w_s_imm), .o_wreg(w_s_wreg), .o_res(w_s_res)
    );

    always_ff @(posedge clk) begin
        if (rstd)
            r_stall <= '0;
        else if (w_main_v && !out_ready && !(&r_stall))
            r_stall <= r_stall + 1'b1;
    end

    assign out_valid   = w_main_v;
    assign pc_out      = w_m_pc;
    assign op_out      = w_main_v ? w_m_op : OP_W'(NOP_OP);
    assign os_out      = w_m_os;
    assign ot_out      = w_m_ot;
    assign imm_dpl_out = w_m_imm;
    assign wreg_out    = w_main_v ? w_m_wreg : '0;
    assign result_out  = w_m_res;
    assign stall_cnt   = r_stall;
endmodule

// File: tb/tb_ew_skid_reg.sv
// Randomised bench for ew_skid_reg against a queue-based reference model.
import pipe_pkg::*;

module tb_ew_skid_reg;
    logic        clk = 0;
    logic        rstd, flush, in_valid, out_ready;
    logic [31:0] pc_in, os_in, ot_in, imm_in, res_in;
    logic [5:0]  op_in;
    logic [4:0]  wreg_in;

    logic        in_ready, out_valid;
    logic [31:0] pc_out, os_out, ot_out, imm_out, res_out;
    logic [5:0]  op_out;
    logic [4:0]  wreg_out;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [31:0] pc_out2, os_out2, ot_out2, imm_out2, res_out2;
    logic [5:0]  op_out2;
    logic [4:0]  wreg_out2;
    logic [3:0]  stall_cnt2;

    int errs = 0;
    int nchk = 0;
    ew_payload_t q[$];
    int cnt16 = 0;
    int cnt4  = 0;

    always #5 clk = ~clk;

    ew_skid_reg dut (
        .clk(clk), .rstd(rstd), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .op_in(op_in), .os_in(os_in), .ot_in(ot_in), .imm_dpl_in(imm_in),
        .wreg_in(wreg_in), .result_in(res_in), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .op_out(op_out), .os_out(os_out), .ot_out(ot_out),
        .imm_dpl_out(imm_out), .wreg_out(wreg_out), .result_out(res_out), .stall_cnt(stall_cnt)
    );

    ew_skid_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rstd(rstd), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .pc_in(pc_in), .op_in(op_in), .os_in(os_in), .ot_in(ot_in), .imm_dpl_in(imm_in),
        .wreg_in(wreg_in), .result_in(res_in), .out_valid(out_valid2), .out_ready(out_ready),
        .pc_out(pc_out2), .op_out(op_out2), .os_out(os_out2), .ot_out(ot_out2),
        .imm_dpl_out(imm_out2), .wreg_out(wreg_out2), .result_out(res_out2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model by the rules, then compare after the edge.
    task automatic step(input bit iv, input bit ordy, input bit fl, input bit rs,
                        input logic [5:0] op, input logic [4:0] wr);
        ew_payload_t e;
        bit          acc, rel;
        e.pc = $urandom; e.os = $urandom; e.ot = $urandom; e.imm_dpl = $urandom; e.result = $urandom;
        e.op = op; e.wreg = wr;
        rstd = rs; flush = fl; in_valid = iv; out_ready = ordy;
        pc_in = e.pc; op_in = op; os_in = e.os; ot_in = e.ot; imm_in = e.imm_dpl;
        wreg_in = wr; res_in = e.result;
        if (rs) begin
            q.delete(); cnt16 = 0; cnt4 = 0;
        end else begin
            if (q.size() > 0 && !ordy) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            acc = iv && (q.size() < 2);
            rel = ordy && (q.size() > 0);
            if (fl) q.delete();
            else begin
                if (rel) void'(q.pop_front());
                if (op == NOP_OP) e.wreg = '0;
                if (acc) q.push_back(e);
            end
        end
        @(posedge clk); #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(cnt16));
        chk("stall_cnt4", 64'(stall_cnt2), 64'(cnt4));
        if (q.size() > 0) begin
            chk("op_out", 64'(op_out), 64'(q[0].op));
            chk("wreg_out", 64'(wreg_out), 64'(q[0].wreg));
            chk("pc_out", 64'(pc_out), 64'(q[0].pc));
            chk("os_out", 64'(os_out), 64'(q[0].os));
            chk("ot_out", 64'(ot_out), 64'(q[0].ot));
            chk("imm_out", 64'(imm_out), 64'(q[0].imm_dpl));
            chk("result_out", 64'(res_out), 64'(q[0].result));
        end else begin
            chk("op_idle", 64'(op_out), 64'(NOP_OP));
            chk("wreg_idle", 64'(wreg_out), 64'd0);
        end
    endtask

    function automatic logic [5:0] rop();
        return ($urandom_range(0, 3) == 0) ? NOP_OP : 6'($urandom);
    endfunction

    initial begin
        rstd = 1; flush = 0; in_valid = 0; out_ready = 0;
        pc_in = 0; op_in = 0; os_in = 0; ot_in = 0; imm_in = 0; wreg_in = 0; res_in = 0;
        // reset
        step(1, 0, 0, 1, 6'd3, 5'd4);
        // streaming
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 6'($urandom_range(0, 54)), 5'($urandom));
        step(0, 1, 0, 0, 6'd0, 5'd0);
        // back-pressure then release
        step(1, 0, 0, 0, 6'd1, 5'd1);
        step(1, 0, 0, 0, 6'd2, 5'd2);
        step(0, 0, 0, 0, 6'd0, 5'd0);
        step(1, 0, 0, 0, 6'd9, 5'd9);
        step(0, 1, 0, 0, 6'd0, 5'd0);
        step(0, 1, 0, 0, 6'd0, 5'd0);
        // bubble sanitising
        step(1, 1, 0, 0, NOP_OP, 5'd7);
        step(1, 1, 0, 0, 6'd0, 5'd7);
        step(0, 1, 0, 0, 6'd0, 5'd0);
        // flush while full with a push offered
        step(1, 0, 0, 0, 6'd4, 5'd4);
        step(1, 0, 0, 0, 6'd5, 5'd5);
        step(1, 1, 1, 0, 6'd6, 5'd6);
        step(0, 1, 0, 0, 6'd0, 5'd0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0,
                 $urandom_range(0, 120) == 0, rop(), 5'($urandom));
        // saturation of the narrow counter
        step(0, 0, 0, 1, 6'd0, 5'd0);
        step(1, 0, 0, 0, 6'd8, 5'd8);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 6'd0, 5'd0);
        // reset while full discards everything
        step(1, 0, 0, 0, 6'd8, 5'd8);
        step(1, 1, 0, 1, 6'd8, 5'd8);
        step(0, 1, 0, 0, 6'd0, 5'd0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
